// File: rtl/fp_pkg.sv
// Shared single-precision float types and helpers for the audio path.
// Used by the window min/max tracker and its comparator.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mm_state_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == FP_EXP_MAX) && (x.mant != '0);
    endfunction

endpackage

// File: rtl/fpcomp.sv
// Combinational IEEE-754 single-precision ordering comparator.
// geq/leq both high on equality (incl. -0 vs +0); both low if either is NaN.
module fpcomp
    import fp_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  geq,
    output logic  leq
);

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_ka;
    logic [31:0] w_kb;
    logic        w_nan;
    logic        w_zeros;

    assign w_a = a;
    assign w_b = b;

    // Map sign-magnitude onto an unsigned key that orders like the value
    assign w_ka = w_a[31] ? ~w_a : {1'b1, w_a[30:0]};
    assign w_kb = w_b[31] ? ~w_b : {1'b1, w_b[30:0]};

    assign w_nan   = is_nan(a) || is_nan(b);
    assign w_zeros = (w_a[30:0] == '0) && (w_b[30:0] == '0);

    always_comb begin
        geq = 1'b0;
        leq = 1'b0;
        if (w_nan) begin
            geq = 1'b0;
            leq = 1'b0;
        end else if (w_zeros) begin
            geq = 1'b1;
            leq = 1'b1;
        end else begin
            geq = (w_ka >= w_kb);
            leq = (w_ka <= w_kb);
        end
    end

endmodule

// File: rtl/fp_window_minmax.sv
// Streaming float min/max over fixed windows of WINDOW samples.
// Define FPMINMAX_ABS_EN to track peak/trough magnitudes instead of signed values.
module fp_window_minmax
    import fp_pkg::*;
#(
    parameter int WINDOW = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_max,
    output logic [31:0] out_min
);

    localparam int            CW   = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    mm_state_t     r_state;
    mm_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_have;
    fp32_t         r_acc_max;
    fp32_t         r_acc_min;
    logic          r_out_valid;
    logic [31:0]   r_out_max;
    logic [31:0]   r_out_min;

    fp32_t w_x;
    fp32_t w_max_nxt;
    fp32_t w_min_nxt;
    logic  w_nan;
    logic  w_max_geq;
    logic  w_max_leq;
    logic  w_min_geq;
    logic  w_min_leq;
    logic  w_upd_max;
    logic  w_upd_min;
    logic  w_have_nxt;
    logic  w_accept;
    logic  w_last;
    logic  w_take_now;
    logic  w_release;

`ifdef FPMINMAX_ABS_EN
    assign w_x = {1'b0, in_data[30:0]};
`else
    assign w_x = in_data;
`endif

    assign w_nan = is_nan(w_x);

    fpcomp u_cmp_max (
        .a   (w_x),
        .b   (r_acc_max),
        .geq (w_max_geq),
        .leq (w_max_leq)
    );

    fpcomp u_cmp_min (
        .a   (w_x),
        .b   (r_acc_min),
        .geq (w_min_geq),
        .leq (w_min_leq)
    );

    // Strict ordering only, so ties keep the value seen first
    assign w_upd_max  = !w_nan && (!r_have || (w_max_geq && !w_max_leq));
    assign w_upd_min  = !w_nan && (!r_have || (w_min_leq && !w_min_geq));
    assign w_max_nxt  = w_upd_max ? w_x : r_acc_max;
    assign w_min_nxt  = w_upd_min ? w_x : r_acc_min;
    assign w_have_nxt = r_have || !w_nan;

    assign in_ready   = (r_state == ACCUM);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = w_accept && (r_cnt == LAST);
    assign w_take_now = w_last && (!r_out_valid || out_ready);
    assign w_release  = (r_state == HOLD) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACCUM: if (w_last && !w_take_now) w_state_nxt = HOLD;
            HOLD:  if (out_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_have    <= 1'b0;
            r_acc_max <= '0;
            r_acc_min <= '0;
        end else if (w_release || w_take_now) begin
            r_cnt  <= '0;
            r_have <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= r_cnt + 1'b1;
            r_have    <= w_have_nxt;
            r_acc_max <= w_max_nxt;
            r_acc_min <= w_min_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_max   <= '0;
            r_out_min   <= '0;
        end else if (w_take_now) begin
            r_out_valid <= 1'b1;
            r_out_max   <= w_have_nxt ? w_max_nxt : FP_QNAN;
            r_out_min   <= w_have_nxt ? w_min_nxt : FP_QNAN;
        end else if (w_release) begin
            r_out_valid <= 1'b1;
            r_out_max   <= r_have ? r_acc_max : FP_QNAN;
            r_out_min   <= r_have ? r_acc_min : FP_QNAN;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;

endmodule

// File: tb/tb_fp_window_minmax.sv
// Self-checking bench for fp_window_minmax (WINDOW=4) against a real-valued model.
// Honors FPMINMAX_ABS_EN in the model when the build defines it.
module tb_fp_window_minmax;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_max;
    logic [31:0] out_min;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] win [W];
    logic [31:0] exp_max;
    logic [31:0] exp_min;
    logic [31:0] prev_s = 32'h3f800000;

    fp_window_minmax #(.WINDOW(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min)
    );

    always #5 clk = ~clk;

    function automatic real fp_val(input logic [31:0] b);
        real m;
        real v;
        int  e;
        e = int'(b[30:23]);
        m = real'(b[22:0]) / 8388608.0;
        if (e == 255) v = 1.0e300;
        else if (e == 0) v = m * (2.0 ** (-126));
        else v = (1.0 + m) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic logic isnan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] prep(input logic [31:0] s);
`ifdef FPMINMAX_ABS_EN
        return {1'b0, s[30:0]};
`else
        return s;
`endif
    endfunction

    task automatic model();
        logic [31:0] x;
        bit have;
        have = 0;
        exp_max = 32'h7FC00000;
        exp_min = 32'h7FC00000;
        for (int i = 0; i < W; i++) begin
            x = prep(win[i]);
            if (!isnan(x)) begin
                if (!have) begin
                    exp_max = x;
                    exp_min = x;
                    have = 1;
                end else begin
                    if (fp_val(x) > fp_val(exp_max)) exp_max = x;
                    if (fp_val(x) < fp_val(exp_min)) exp_min = x;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] s;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) s = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
        else if (r == 1) s = {1'($urandom), 31'd0};
        else if (r == 2) s = prev_s;
        else if (r == 3) s = {1'($urandom), 8'hFF, 23'd0};
        else s = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        prev_s = s;
        return s;
    endfunction

    task automatic gen_window();
        for (int i = 0; i < W; i++) win[i] = rand_fp();
        model();
    endtask

    // Called at a negedge; returns at the negedge after the sample is taken
    task automatic drive(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_window();
        for (int i = 0; i < W; i++) drive(win[i]);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        if (out_max !== 32'h0) begin failures++; $display("FAIL rst_max got=%h exp=0", out_max); end
        if (out_min !== 32'h0) begin failures++; $display("FAIL rst_min got=%h exp=0", out_min); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        win[0] = 32'h3fc00000; win[1] = 32'hbfc00000;
        win[2] = 32'h3fcccccd; win[3] = 32'h80000000;
        model();
        send_window();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        if (out_max !== exp_max) begin failures++; $display("FAIL basic_max got=%h exp=%h", out_max, exp_max); end
        if (out_min !== exp_min) begin failures++; $display("FAIL basic_min got=%h exp=%h", out_min, exp_min); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_tie();
        win[0] = 32'h80000000; win[1] = 32'h00000000;
        win[2] = 32'h00000000; win[3] = 32'h80000000;
        model();
        send_window();
        in_valid = 1'b0;
        checks += 2;
        if (out_max !== exp_max) begin failures++; $display("FAIL tie_max got=%h exp=%h", out_max, exp_max); end
        if (out_min !== exp_min) begin failures++; $display("FAIL tie_min got=%h exp=%h", out_min, exp_min); end
    endtask

    task automatic test_nan();
        win[0] = 32'h7fc00001; win[1] = 32'h40200000;
        win[2] = 32'hffc00000; win[3] = 32'h3fc00000;
        model();
        send_window();
        checks += 2;
        if (out_max !== exp_max) begin failures++; $display("FAIL nan_max got=%h exp=%h", out_max, exp_max); end
        if (out_min !== exp_min) begin failures++; $display("FAIL nan_min got=%h exp=%h", out_min, exp_min); end
        win[0] = 32'h7f800001; win[1] = 32'hffffffff;
        win[2] = 32'h7fc00000; win[3] = 32'hff800010;
        model();
        send_window();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL allnan_valid got=%b exp=1", out_valid); end
        if (out_max !== exp_max) begin failures++; $display("FAIL allnan_max got=%h exp=%h", out_max, exp_max); end
        if (out_min !== exp_min) begin failures++; $display("FAIL allnan_min got=%h exp=%h", out_min, exp_min); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int w = 0; w < 12; w++) begin
            gen_window();
            send_window();
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid w=%0d got=%b exp=1", w, out_valid); end
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready w=%0d got=%b exp=1", w, in_ready); end
            if (out_max !== exp_max) begin failures++; $display("FAIL b2b_max w=%0d got=%h exp=%h", w, out_max, exp_max); end
            if (out_min !== exp_min) begin failures++; $display("FAIL b2b_min w=%0d got=%h exp=%h", w, out_min, exp_min); end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] m1x, m1n, m2x, m2n;
        out_ready = 1'b0;
        gen_window();
        m1x = exp_max; m1n = exp_min;
        send_window();
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp1_valid got=%b exp=1", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp1_ready got=%b exp=1", in_ready); end
        if (out_max !== m1x) begin failures++; $display("FAIL bp1_max got=%h exp=%h", out_max, m1x); end
        if (out_min !== m1n) begin failures++; $display("FAIL bp1_min got=%h exp=%h", out_min, m1n); end
        gen_window();
        m2x = exp_max; m2n = exp_min;
        send_window();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
        if (out_max !== m1x) begin failures++; $display("FAIL bp_stable_max got=%h exp=%h", out_max, m1x); end
        if (out_min !== m1n) begin failures++; $display("FAIL bp_stable_min got=%h exp=%h", out_min, m1n); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp2_valid got=%b exp=1", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp2_ready got=%b exp=1", in_ready); end
        if (out_max !== m2x) begin failures++; $display("FAIL bp2_max got=%h exp=%h", out_max, m2x); end
        if (out_min !== m2n) begin failures++; $display("FAIL bp2_min got=%h exp=%h", out_min, m2n); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp2_keep got=%b exp=1", out_valid); end
        // Final sample lands in the same cycle the pending result is taken
        gen_window();
        for (int i = 0; i < W - 1; i++) drive(win[i]);
        out_ready = 1'b1;
        drive(win[W-1]);
        in_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp3_valid got=%b exp=1", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp3_ready got=%b exp=1", in_ready); end
        if (out_max !== exp_max) begin failures++; $display("FAIL bp3_max got=%h exp=%h", out_max, exp_max); end
        if (out_min !== exp_min) begin failures++; $display("FAIL bp3_min got=%h exp=%h", out_min, exp_min); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp3_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        win[0] = 32'h40400000; win[1] = 32'hc0400000;
        win[2] = 32'h3f800000; win[3] = 32'h3f000000;
        model();
        send_window();
        drive(32'h42000000);
        drive(32'hc2000000);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        if (out_max !== 32'h0) begin failures++; $display("FAIL rmid_max got=%h exp=0", out_max); end
        if (out_min !== 32'h0) begin failures++; $display("FAIL rmid_min got=%h exp=0", out_min); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        gen_window();
        for (int i = 0; i < W - 1; i++) drive(win[i]);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_early got=%b exp=0", out_valid); end
        drive(win[W-1]);
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_fresh_valid got=%b exp=1", out_valid); end
        if (out_max !== exp_max) begin failures++; $display("FAIL rmid_fresh_max got=%h exp=%h", out_max, exp_max); end
        if (out_min !== exp_min) begin failures++; $display("FAIL rmid_fresh_min got=%h exp=%h", out_min, exp_min); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_nan();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
